// File: rtl/axis_fifo_master_pkt.sv
// axis_fifo_master_pkt
// Drains a read-latency-1 FIFO onto an AXI4-Stream master port at one beat
// per cycle. An output register plus one skid register absorb the FIFO read
// latency. Packets are framed with TLAST every pkt_len beats, and completed
// packets are counted.
// Optional build macro AXIS_TUSER_SOF_EN adds a 1-bit M_AXIS_TUSER output
// that marks the first beat of every packet.

module axis_fifo_master_pkt #(
  parameter int C_M_AXIS_TDATA_WIDTH = 32,
  parameter int C_PKT_LEN_WIDTH      = 16,
  parameter int C_PKT_CNT_WIDTH      = 32
) (
  input  logic                            M_AXIS_ACLK,
  input  logic                            M_AXIS_ARESETN,
  output logic                            M_AXIS_TVALID,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0] M_AXIS_TDATA,
  output logic                            M_AXIS_TLAST,
`ifdef AXIS_TUSER_SOF_EN
  output logic                            M_AXIS_TUSER,
`endif
  input  logic                            M_AXIS_TREADY,
  input  logic [C_M_AXIS_TDATA_WIDTH-1:0] fifo_dout,
  output logic                            fifo_rd_en,
  input  logic                            fifo_empty,
  input  logic                            enable,
  input  logic [C_PKT_LEN_WIDTH-1:0]      pkt_len,
  output logic [C_PKT_CNT_WIDTH-1:0]      pkt_count
);

  localparam logic [C_PKT_LEN_WIDTH-1:0] LEN_ZERO = '0;
  localparam logic [C_PKT_LEN_WIDTH-1:0] LEN_ONE  = {{(C_PKT_LEN_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [C_PKT_CNT_WIDTH-1:0] CNT_ONE  = {{(C_PKT_CNT_WIDTH-1){1'b0}}, 1'b1};

  logic                            skid_valid;
  logic [C_M_AXIS_TDATA_WIDTH-1:0] skid_data;
  logic                            inflight;
  logic [C_PKT_LEN_WIDTH-1:0]      beat_cnt;
  logic [C_PKT_LEN_WIDTH-1:0]      len_q;

  logic                            pop;
  logic [1:0]                      occ;
  logic [2:0]                      owed;
  logic                            load_from_skid;
  logic                            load_from_fifo;
  logic                            load_out;
  logic                            skid_load;
  logic [C_M_AXIS_TDATA_WIDTH-1:0] load_data;
  logic [C_PKT_LEN_WIDTH-1:0]      eff_len;
  logic [C_PKT_LEN_WIDTH-1:0]      cur_len;
  logic                            beat_is_last;

  // Handshake, buffer occupancy and the pop request. owed counts beats held
  // or still coming back from the FIFO after this cycle's pop; keeping it
  // below 2 guarantees a returning word always has a register to land in.
  always_comb begin
    pop        = M_AXIS_TVALID & M_AXIS_TREADY;
    occ        = {1'b0, M_AXIS_TVALID} + {1'b0, skid_valid};
    owed       = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    fifo_rd_en = M_AXIS_ARESETN & enable & ~fifo_empty & (owed < 3'd2);
  end

  // Routing of data into the output register: skid has priority so FIFO
  // order is preserved; a returning word bypasses the skid only when it is empty.
  always_comb begin
    load_from_skid = pop & skid_valid;
    load_from_fifo = inflight & ~skid_valid & (~M_AXIS_TVALID | pop);
    load_out       = load_from_skid | load_from_fifo;
    skid_load      = inflight & ~load_from_fifo;
    load_data      = load_from_skid ? skid_data : fifo_dout;
  end

  // Framing: a new packet samples pkt_len (0 means 1); mid-packet beats use
  // the latched length so pkt_len changes only affect the next packet.
  always_comb begin
    eff_len      = (pkt_len == LEN_ZERO) ? LEN_ONE : pkt_len;
    cur_len      = (beat_cnt == LEN_ZERO) ? eff_len : len_q;
    beat_is_last = (beat_cnt == (cur_len - LEN_ONE));
  end

  // Tracks whether a FIFO word is due back this cycle.
  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) begin
      inflight <= 1'b0;
    end else begin
      inflight <= fifo_rd_en;
    end
  end

  // Skid register: catches a returning word when the output register is busy.
  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) begin
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (skid_load) begin
      skid_valid <= 1'b1;
      skid_data  <= fifo_dout;
    end else if (load_from_skid) begin
      skid_valid <= 1'b0;
    end
  end

  // Output register: payload and sideband are loaded together and held until handshake.
  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) begin
      M_AXIS_TVALID <= 1'b0;
      M_AXIS_TDATA  <= '0;
      M_AXIS_TLAST  <= 1'b0;
    end else if (load_out) begin
      M_AXIS_TVALID <= 1'b1;
      M_AXIS_TDATA  <= load_data;
      M_AXIS_TLAST  <= beat_is_last;
    end else if (pop) begin
      M_AXIS_TVALID <= 1'b0;
    end
  end

`ifdef AXIS_TUSER_SOF_EN
  // Start-of-frame flag registered with the beat it describes.
  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) begin
      M_AXIS_TUSER <= 1'b0;
    end else if (load_out) begin
      M_AXIS_TUSER <= (beat_cnt == LEN_ZERO);
    end
  end
`endif

  // Beat index within the packet and the length latched at packet start.
  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) begin
      beat_cnt <= '0;
      len_q    <= '0;
    end else if (load_out) begin
      if (beat_cnt == LEN_ZERO) begin
        len_q <= eff_len;
      end
      beat_cnt <= beat_is_last ? LEN_ZERO : (beat_cnt + LEN_ONE);
    end
  end

  // Completed-packet counter, wraps naturally at its width.
  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) begin
      pkt_count <= '0;
    end else if (pop && M_AXIS_TLAST) begin
      pkt_count <= pkt_count + CNT_ONE;
    end
  end

endmodule
